bip_run_ctrl: RTL
=================

# bip_run_ctrl

Run controller for the BIP single-cycle processor. It decides, cycle by cycle, whether the core executes the instruction currently at the program-memory output. It sequences free-run, single-step, stop and halt-on-HLT, and counts executed instructions. `Exec_En` is ANDed into the core's PC, ACC and data-RAM write enables, so a disabled cycle leaves all architectural state unchanged.

## Interface
Parameters:
- `CNT_BITS`, default 16: width of `Instr_Count`.
- `HLT_OPCODE`, default 5'b00000: opcode that halts the core.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `Start`, in, 1: request free-run; sampled on `Clk`.
- `Step`, in, 1: request execution of exactly one instruction; sampled on `Clk`.
- `Stop`, in, 1: request return to IDLE from RUN; sampled on `Clk`.
- `Opcode`, in, 5: opcode of the current instruction (program-memory data [15:11]).
- `Exec_En`, out, 1: execute the current instruction this cycle.
- `Busy`, out, 1: state is RUN or STEP.
- `Halted`, out, 1: state is HALTED.
- `Done`, out, 1: one-cycle pulse on entry to HALTED.
- `Instr_Count`, out, `CNT_BITS`: number of executed instructions.

## Operation
- States: IDLE, RUN, STEP, HALTED. Reset state is IDLE.
- `Exec_En` = (state is RUN or STEP) and (`Opcode` != `HLT_OPCODE`). It is a combinational decode of the state register and `Opcode`; no other input feeds it.
- IDLE:
  - `Start` -> RUN.
  - else `Step` -> STEP.
  - `Stop` is ignored.
  - `Start` has priority over `Step`.
- RUN:
  - `Opcode` == HLT -> HALTED.
  - else `Stop` -> IDLE.
  - else stay in RUN.
  - HLT has priority over `Stop`.
  - `Start` and `Step` are ignored.
- STEP:
  - `Opcode` == HLT -> HALTED.
  - else -> IDLE unconditionally, so exactly one instruction executes.
  - All requests are ignored.
- HALTED: absorbing. `Start`, `Step` and `Stop` are ignored; only `Reset` exits.
- `Done` is registered. It is 1 in the first cycle in HALTED and 0 otherwise.
- `Instr_Count` increments by 1 at each rising edge where `Exec_En` = 1.
  - Saturates at all-ones (no wrap).
  - Cleared only by `Reset`.
  - An HLT cycle is not counted.

## Timing
- Reset values: state IDLE; `Exec_En`, `Busy`, `Halted` and `Done` = 0; `Instr_Count` = 0.
- `Reset` asserted mid-operation forces IDLE and `Exec_En` = 0 immediately, without waiting for a clock edge.
- `Start` high at edge k puts the controller in RUN after edge k. The first instruction executes in the cycle ending at edge k+1 (one cycle of request latency).
- `Step` high at edge k gives `Exec_En` = 1 during cycle k..k+1 only, then IDLE.
- `Stop` high at edge k in RUN: the instruction in the cycle ending at edge k still executes. `Exec_En` = 0 from edge k.
- HLT visible on `Opcode` in RUN or STEP:
  - `Exec_En` = 0 in that same cycle, so PC does not advance and the core stays parked on HLT.
  - HALTED after the next edge, with `Done` high for that one cycle.
- `Start` and `Step` are level-sampled. A request held high in IDLE after a STEP produces another step on each qualifying edge.

## Configuration
- `BIP_INSTR_COUNT_EN` defined: counter present and behaving as specified above.
- `BIP_INSTR_COUNT_EN` undefined: counter logic removed; `Instr_Count` is tied to 0. Port list unchanged.

## Structure
- Shared package `bip_pkg` holds:
  - the state enum `bip_run_state_t` (IDLE, RUN, STEP, HALTED);
  - `BIP_OPCODE_W` = 5;
  - `BIP_HLT_OPCODE` = 5'b00000, which is also used as the default for `HLT_OPCODE`.
- One sub-module: `bip_sat_counter`, parameterised width, async active-high reset, increment enable, saturating at all-ones. It is instantiated only under `BIP_INSTR_COUNT_EN`.

## Test plan
- Reset, then `Start` pulse with non-HLT opcodes for 5 cycles, then `Opcode` = 00000 -> `Exec_En` high for exactly 5 cycles, 0 on the HLT cycle; `Done` = 1 for one cycle; `Halted` = 1; `Instr_Count` = 5.
- In IDLE, three separate one-cycle `Step` pulses -> three single `Exec_En` cycles, each followed by IDLE; `Instr_Count` = 3.
- In RUN, `Stop` and an HLT opcode in the same cycle -> HALTED, not IDLE; `Done` pulses.
- In HALTED, assert `Start`, `Step` and `Stop` -> state stays HALTED, `Exec_En` = 0, `Done` does not re-pulse.
- With `CNT_BITS` = 4, run 20 non-HLT cycles -> `Instr_Count` saturates at 15. Build without `BIP_INSTR_COUNT_EN` -> `Instr_Count` stays 0.
- Assert `Reset` mid-RUN between clock edges -> `Exec_En` and `Busy` drop immediately, state is IDLE, `Instr_Count` = 0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP core: opcode width, HLT encoding and the
// run-controller state type.
package bip_pkg;

  localparam int unsigned BIP_OPCODE_W = 5;
  localparam logic [BIP_OPCODE_W-1:0] BIP_HLT_OPCODE = 5'b00000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } bip_run_state_t;

endpackage

// File: rtl/bip_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones,
// cleared only by the asynchronous active-high reset.
module bip_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc until every bit is set, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bip_run_ctrl.sv
// Run controller for the BIP single-cycle core. Gates architectural writes
// through Exec_En and sequences free-run, single-step, stop and halt.
// Build option: define BIP_INSTR_COUNT_EN to include the executed-instruction
// counter; otherwise Instr_Count is tied to zero.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | core parked, waiting for Start (free-run) or Step
//  RUN    | executing every cycle until HLT or Stop
//  STEP   | executing exactly one instruction, then back to IDLE
//  HALTED | HLT seen; absorbing until Reset
module bip_run_ctrl
  import bip_pkg::*;
#(
  parameter int unsigned              CNT_BITS   = 16,
  parameter logic [BIP_OPCODE_W-1:0] HLT_OPCODE = BIP_HLT_OPCODE
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Step,
  input  logic                    Stop,
  input  logic [BIP_OPCODE_W-1:0] Opcode,
  output logic                    Exec_En,
  output logic                    Busy,
  output logic                    Halted,
  output logic                    Done,
  output logic [CNT_BITS-1:0]     Instr_Count
);

  bip_run_state_t state_q;
  bip_run_state_t state_d;
  logic           is_hlt;

  assign is_hlt = (Opcode == HLT_OPCODE);

  // State register; Reset drops the core to IDLE without waiting for a clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d = state_q;
    Exec_En = 1'b0;
    Busy    = 1'b0;
    Halted  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
        end else if (Step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        Busy    = 1'b1;
        Exec_En = !is_hlt;
        if (is_hlt) begin
          state_d = HALTED;
        end else if (Stop) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        Busy    = 1'b1;
        Exec_En = !is_hlt;
        state_d = is_hlt ? HALTED : IDLE;
      end
      HALTED: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Done marks only the first cycle spent in HALTED.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Done <= 1'b0;
    end else begin
      Done <= (state_q != HALTED) && (state_d == HALTED);
    end
  end

`ifdef BIP_INSTR_COUNT_EN
  bip_sat_counter #(
    .WIDTH (CNT_BITS)
  ) u_instr_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (Exec_En),
    .count (Instr_Count)
  );
`else
  assign Instr_Count = '0;
`endif

endmodule
